// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : opcode, width and state constants shared by the SPI master.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_SHIFT_CMD = 3'd2;
  localparam logic [2:0] ST_WAIT_RD   = 3'd3;
  localparam logic [2:0] ST_SHIFT_RD  = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  // Only read-data commands make the slave drive a response byte.
  function automatic logic has_response(input logic [1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: r = 1'b0;
      CMD_RD_DATA:                           r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_reg.sv
// ============================================================================
// spi_shift_reg : parallel-load, MSB-first shift register with serial input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// spi_master : 10-bit command SPI master with optional read-byte capture.
// Optional frame counter output enabled by macro SPI_MASTER_FRAME_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 3,
  parameter int MIN_GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FRAME_W-1:0] req_data,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
`ifdef SPI_MASTER_FRAME_CNT_EN
  output logic [15:0]       frame_cnt,
`endif
  output logic              busy
);

  localparam logic [3:0] CMD_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] RD_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  logic [2:0]         state;
  logic [2:0]         nxt;
  logic [3:0]         cnt;
  logic [3:0]         cnt_nxt;
  logic [3:0]         wait_last;
  logic               is_rd;
  logic               handshake;
  logic               rd_done;
  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-1:0]  rx_q;
  logic               unused_bits;

  assign handshake = req_valid && req_ready;
  assign wait_last = is_rd ? LAT_LAST : 4'd0;
  assign rd_done   = (state == ST_SHIFT_RD) && (nxt == ST_GAP);

  // Only the MSB of TX and the low bits of RX are observed at the top.
  assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[DATA_W-1]};

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = 4'd0;
        if (handshake) nxt = ST_START;
      end
      ST_START: begin
        nxt     = ST_SHIFT_CMD;
        cnt_nxt = 4'd0;
      end
      ST_SHIFT_CMD: begin
        if (cnt == CMD_LAST) begin
          nxt     = ST_WAIT_RD;
          cnt_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      // Writes pass through here for a single guard cycle.
      ST_WAIT_RD: begin
        if (cnt == wait_last) begin
          nxt     = is_rd ? ST_SHIFT_RD : ST_GAP;
          cnt_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_SHIFT_RD: begin
        if (cnt == RD_LAST) begin
          nxt     = ST_GAP;
          cnt_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          nxt     = ST_IDLE;
          cnt_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        nxt     = ST_IDLE;
        cnt_nxt = 4'd0;
      end
    endcase
  end

  spi_shift_reg #(.WIDTH(FRAME_W)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (handshake),
    .load_data (req_data),
    .shift_en  (nxt == ST_SHIFT_CMD),
    .sin       (1'b0),
    .q         (tx_q)
  );

  spi_shift_reg #(.WIDTH(DATA_W)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (state == ST_SHIFT_RD),
    .sin       (miso),
    .q         (rx_q)
  );

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      is_rd     <= 1'b0;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      if (handshake) is_rd <= has_response(req_data[FRAME_W-1:FRAME_W-2]);
      ss_n      <= (nxt == ST_IDLE) || (nxt == ST_GAP);
      mosi      <= (nxt == ST_SHIFT_CMD) ? tx_q[FRAME_W-1] : 1'b0;
      busy      <= (nxt != ST_IDLE);
      req_ready <= (nxt == ST_IDLE);
      rd_valid  <= rd_done;
      if (rd_done) rd_data <= {rx_q[DATA_W-2:0], miso};
    end
  end

`ifdef SPI_MASTER_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if ((nxt == ST_GAP) && (state != ST_GAP)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// tb_spi_master : directed self-checking bench for spi_master.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;

  localparam int NCYC = 30;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_data;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ss_v, mosi_v, rdy_v, busy_v, rdv_v;
  logic [7:0]  rdd [NCYC];

  spi_master #(.RD_LATENCY(3), .MIN_GAP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
`ifdef SPI_MASTER_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int k);
    ss_v[k]   = ss_n;
    mosi_v[k] = mosi;
    rdy_v[k]  = req_ready;
    busy_v[k] = busy;
    rdv_v[k]  = rd_valid;
    rdd[k]    = rd_data;
  endtask

  // Cycle 0 is the handshake cycle; cycles 1..NCYC-1 follow it.
  task automatic run_frame(input logic [9:0] cmd1, input logic [9:0] cmd2, input bit b2b,
                           input logic [7:0] rx_byte, input int pulse_k);
    ss_v = '0; mosi_v = '0; rdy_v = '0; busy_v = '0; rdv_v = '0;
    req_data  = cmd1;
    req_valid = 1'b1;
    record(0);
    for (int k = 1; k < NCYC; k++) begin
      step();
      if (k == 1) begin
        if (b2b) req_data = cmd2;
        else     req_valid = 1'b0;
      end
      if (b2b && k == 15) req_valid = 1'b0;
      if (k == pulse_k) begin
        req_valid = 1'b1;
        req_data  = 10'h3FF;
      end else if (k == pulse_k + 1) begin
        req_valid = 1'b0;
      end
      miso = (k >= 15 && k <= 22) ? rx_byte[22-k] : 1'b0;
      record(k);
    end
    req_valid = 1'b0;
    miso      = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    miso      = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check_eq("rst_ss_n",      32'(ss_n),      32'h1);
    check_eq("rst_mosi",      32'(mosi),      32'h0);
    check_eq("rst_rd_data",   32'(rd_data),   32'h0);
    check_eq("rst_rd_valid",  32'(rd_valid),  32'h0);
    check_eq("rst_busy",      32'(busy),      32'h0);
    check_eq("rst_req_ready", 32'(req_ready), 32'h1);

    // Abort a write during command bit 4 (cycle T+6).
    req_data  = 10'h0A5;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    check_eq("abort_pre_mosi", 32'(mosi), 32'h1);
    check_eq("abort_pre_ss_n", 32'(ss_n), 32'h0);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_ss_n",      32'(ss_n),      32'h1);
    check_eq("abort_req_ready", 32'(req_ready), 32'h1);
    check_eq("abort_busy",      32'(busy),      32'h0);
    #2 rst = 1'b0;
    step();
    check_eq("abort_idle_ready", 32'(req_ready), 32'h1);
`ifdef SPI_MASTER_FRAME_CNT_EN
    check_eq("abort_frame_cnt", 32'(frame_cnt), 32'h0);
`endif

    run_frame(10'h300, 10'h000, 1'b0, 8'hC3, -1);
    check_eq("rd_ss_n",     ss_v,   32'h3F800001);
    check_eq("rd_mosi",     mosi_v, 32'h0000000C);
    check_eq("rd_ready",    rdy_v,  32'h3F000001);
    check_eq("rd_busy",     busy_v, 32'h00FFFFFE);
    check_eq("rd_valid",    rdv_v,  32'h00800000);
    check_eq("rd_data_pre", 32'(rdd[22]), 32'h00);
    check_eq("rd_data",     32'(rdd[23]), 32'hC3);
`ifdef SPI_MASTER_FRAME_CNT_EN
    check_eq("rd_frame_cnt", 32'(frame_cnt), 32'h1);
`endif

    run_frame(10'h0A5, 10'h000, 1'b0, 8'h00, -1);
    check_eq("wr_ss_n",    ss_v,   32'h3FFFE001);
    check_eq("wr_mosi",    mosi_v, 32'h00000A50);
    check_eq("wr_ready",   rdy_v,  32'h3FFFC001);
    check_eq("wr_busy",    busy_v, 32'h00003FFE);
    check_eq("wr_rd_valid", rdv_v, 32'h0);
    check_eq("wr_rd_hold", 32'(rdd[29]), 32'hC3);
`ifdef SPI_MASTER_FRAME_CNT_EN
    check_eq("wr_frame_cnt", 32'(frame_cnt), 32'h2);
`endif

    run_frame(10'h300, 10'h000, 1'b0, 8'h5A, 17);
    check_eq("bz_ss_n",     ss_v,   32'h3F800001);
    check_eq("bz_mosi",     mosi_v, 32'h0000000C);
    check_eq("bz_ready",    rdy_v,  32'h3F000001);
    check_eq("bz_busy",     busy_v, 32'h00FFFFFE);
    check_eq("bz_valid",    rdv_v,  32'h00800000);
    check_eq("bz_data_pre", 32'(rdd[22]), 32'hC3);
    check_eq("bz_data",     32'(rdd[23]), 32'h5A);
`ifdef SPI_MASTER_FRAME_CNT_EN
    check_eq("bz_frame_cnt", 32'(frame_cnt), 32'h3);
`endif

    run_frame(10'h112, 10'h2FF, 1'b1, 8'h00, -1);
    check_eq("b2b_ss_n",     ss_v,   32'h38006001);
    check_eq("b2b_mosi",     mosi_v, 32'h03FD0488);
    check_eq("b2b_ready",    rdy_v,  32'h30004001);
    check_eq("b2b_busy",     busy_v, 32'h0FFFBFFE);
    check_eq("b2b_rd_valid", rdv_v,  32'h0);
`ifdef SPI_MASTER_FRAME_CNT_EN
    check_eq("b2b_frame_cnt", 32'(frame_cnt), 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
